// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: decode/writeback <-> scoreboard signal bundle.
//   master : decode/writeback side (drives issue_* / decode_read_* / wb_*,
//            receives stall, issue_accept, pending_mask, busy, err_underflow)
//   slave  : the scoreboard itself
interface reg_scoreboard_if;
  logic        issue_valid;
  logic        issue_reg_write;
  logic        issue_is_load;
  logic [4:0]  issue_dest;
  logic [4:0]  decode_read_reg1;
  logic [4:0]  decode_read_reg2;
  logic        wb_valid;
  logic        wb_is_load;
  logic [4:0]  wb_dest;
  logic        stall;
  logic        issue_accept;
  logic [31:0] pending_mask;
  logic        busy;
  logic        err_underflow;

  modport master (
    output issue_valid, issue_reg_write, issue_is_load, issue_dest,
           decode_read_reg1, decode_read_reg2,
           wb_valid, wb_is_load, wb_dest,
    input  stall, issue_accept, pending_mask, busy, err_underflow
  );

  modport slave (
    input  issue_valid, issue_reg_write, issue_is_load, issue_dest,
           decode_read_reg1, decode_read_reg2,
           wb_valid, wb_is_load, wb_dest,
    output stall, issue_accept, pending_mask, busy, err_underflow
  );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks in-flight register writes between decode issue and
// writeback, and raises the decode stall that forwarding cannot cover.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   sb    : reg_scoreboard_if.slave (issue/source/writeback inputs;
//           stall, issue_accept, pending_mask, busy, err_underflow outputs)
// Parameter CNT_W: width of each per-register in-flight counter.
// Build option SCOREBOARD_FWD_EN: when defined, only pending loads stall
// sources (per-register load counters kept); otherwise any pending write does.
module reg_scoreboard #(
  parameter int unsigned CNT_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  reg_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Register 0 carries no state; index 0 of the effective arrays is tied to 0.
  logic [CNT_W-1:0] r_cnt_all [1:31];
  logic [CNT_W-1:0] w_eff_all [32];
  logic [CNT_W-1:0] w_nxt_all [1:31];
  logic [31:0]      w_wb_hit;
  logic [31:0]      w_dec_all;
  logic [31:0]      w_inc_all;
  logic [31:0]      w_pending;
  logic             w_underflow;
  logic             w_haz1;
  logic             w_haz2;
  logic             w_cap;
  logic             w_stall;
  logic             w_accept;
  logic             w_wb_en;
  logic             w_inc_en;
  logic             r_err;

`ifdef SCOREBOARD_FWD_EN
  logic [CNT_W-1:0] r_cnt_load [1:31];
  logic [CNT_W-1:0] w_eff_load [32];
  logic [CNT_W-1:0] w_nxt_load [1:31];
  logic [31:0]      w_dec_load;
  logic [31:0]      w_inc_load;
`else
  logic             w_unused_load;
  assign w_unused_load = sb.issue_is_load ^ sb.wb_is_load;
`endif

  assign w_wb_en = sb.wb_valid && (sb.wb_dest != 5'd0);

  // Effective counts: registered counts after this cycle's writeback
  // (write-first), before this cycle's issue. Decrement of zero is dropped.
  always_comb begin
    w_underflow  = 1'b0;
    w_wb_hit     = '0;
    w_dec_all    = '0;
    w_eff_all[0] = '0;
`ifdef SCOREBOARD_FWD_EN
    w_dec_load    = '0;
    w_eff_load[0] = '0;
`endif
    for (int unsigned r = 1; r < 32; r++) begin
      w_wb_hit[r]  = w_wb_en && (sb.wb_dest == 5'(r));
      w_dec_all[r] = w_wb_hit[r] && (r_cnt_all[r] != '0);
      if (w_wb_hit[r] && (r_cnt_all[r] == '0)) w_underflow = 1'b1;
      w_eff_all[r] = r_cnt_all[r] - CNT_W'(w_dec_all[r]);
`ifdef SCOREBOARD_FWD_EN
      w_dec_load[r] = w_wb_hit[r] && sb.wb_is_load && (r_cnt_load[r] != '0);
      if (w_wb_hit[r] && sb.wb_is_load && (r_cnt_load[r] == '0)) w_underflow = 1'b1;
      w_eff_load[r] = r_cnt_load[r] - CNT_W'(w_dec_load[r]);
`endif
    end
  end

  always_comb begin
`ifdef SCOREBOARD_FWD_EN
    w_haz1 = (sb.decode_read_reg1 != 5'd0) && (w_eff_load[sb.decode_read_reg1] != '0);
    w_haz2 = (sb.decode_read_reg2 != 5'd0) && (w_eff_load[sb.decode_read_reg2] != '0);
`else
    w_haz1 = (sb.decode_read_reg1 != 5'd0) && (w_eff_all[sb.decode_read_reg1] != '0);
    w_haz2 = (sb.decode_read_reg2 != 5'd0) && (w_eff_all[sb.decode_read_reg2] != '0);
`endif
    w_cap   = sb.issue_reg_write && (sb.issue_dest != 5'd0) &&
              (w_eff_all[sb.issue_dest] == CNT_MAX);
    w_stall = sb.issue_valid && (w_haz1 || w_haz2 || w_cap);
  end

  assign w_accept = sb.issue_valid && !w_stall;
  assign w_inc_en = w_accept && sb.issue_reg_write && (sb.issue_dest != 5'd0);

  // Issue and writeback on the same register in one cycle cancel out.
  always_comb begin
    w_inc_all = '0;
`ifdef SCOREBOARD_FWD_EN
    w_inc_load = '0;
`endif
    for (int unsigned r = 1; r < 32; r++) begin
      w_inc_all[r] = w_inc_en && (sb.issue_dest == 5'(r));
      w_nxt_all[r] = r_cnt_all[r] + CNT_W'(w_inc_all[r]) - CNT_W'(w_dec_all[r]);
`ifdef SCOREBOARD_FWD_EN
      w_inc_load[r] = w_inc_all[r] && sb.issue_is_load;
      w_nxt_load[r] = r_cnt_load[r] + CNT_W'(w_inc_load[r]) - CNT_W'(w_dec_load[r]);
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 1; r < 32; r++) begin
        r_cnt_all[r] <= '0;
`ifdef SCOREBOARD_FWD_EN
        r_cnt_load[r] <= '0;
`endif
      end
      r_err <= 1'b0;
    end else begin
      for (int unsigned r = 1; r < 32; r++) begin
        r_cnt_all[r] <= w_nxt_all[r];
`ifdef SCOREBOARD_FWD_EN
        r_cnt_load[r] <= w_nxt_load[r];
`endif
      end
      r_err <= r_err | w_underflow;
    end
  end

  always_comb begin
    w_pending = '0;
    for (int unsigned r = 1; r < 32; r++) begin
      w_pending[r] = (r_cnt_all[r] != '0);
    end
  end

  assign sb.stall         = w_stall;
  assign sb.issue_accept  = w_accept;
  assign sb.pending_mask  = w_pending;
  assign sb.busy          = |w_pending;
  assign sb.err_underflow = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;
  localparam int unsigned CNT_W = 2;
  localparam int MAXC = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_scoreboard_if u_if ();

  reg_scoreboard #(.CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .sb    (u_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain per-register in-flight counts.
  int m_all  [32];
  int m_load [32];
  bit m_err;

`ifdef SCOREBOARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int eff_all(int r);
    if (r == 0) return 0;
    if (u_if.wb_valid && int'(u_if.wb_dest) == r && m_all[r] > 0) return m_all[r] - 1;
    return m_all[r];
  endfunction

  function automatic int eff_load(int r);
    if (r == 0) return 0;
    if (u_if.wb_valid && u_if.wb_is_load && int'(u_if.wb_dest) == r && m_load[r] > 0)
      return m_load[r] - 1;
    return m_load[r];
  endfunction

  function automatic bit src_haz(int s);
    if (s == 0) return 1'b0;
    if (FWD) return eff_load(s) != 0;
    return eff_all(s) != 0;
  endfunction

  function automatic bit exp_stall();
    bit cap;
    if (!u_if.issue_valid) return 1'b0;
    cap = u_if.issue_reg_write && u_if.issue_dest != 5'd0 &&
          eff_all(int'(u_if.issue_dest)) == MAXC;
    return src_haz(int'(u_if.decode_read_reg1)) || src_haz(int'(u_if.decode_read_reg2)) || cap;
  endfunction

  function automatic logic [31:0] exp_pending();
    logic [31:0] p = '0;
    for (int r = 1; r < 32; r++) p[r] = (m_all[r] != 0);
    return p;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      m_all[r]  = 0;
      m_load[r] = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    bit st;
    st = exp_stall();
    check({tag, "_stall"},   u_if.stall, st);
    check({tag, "_accept"},  u_if.issue_accept, u_if.issue_valid && !st);
    check({tag, "_pending"}, u_if.pending_mask, exp_pending());
    check({tag, "_busy"},    u_if.busy, exp_pending() != 0);
    check({tag, "_err"},     u_if.err_underflow, m_err);
  endtask

  task automatic model_advance();
    int n_all [32];
    int n_load[32];
    bit acc;
    int d, wd;
    bit hit, da, dl, ia, il;
    acc = u_if.issue_valid && !exp_stall();
    d   = (acc && u_if.issue_reg_write) ? int'(u_if.issue_dest) : 0;
    wd  = u_if.wb_valid ? int'(u_if.wb_dest) : 0;
    for (int r = 1; r < 32; r++) begin
      hit = (wd == r);
      ia  = (d == r);
      da  = hit && m_all[r] > 0;
      if (hit && m_all[r] == 0) m_err = 1'b1;
      n_all[r] = (m_all[r] + int'(ia) - int'(da)) & MAXC;
      if (FWD) begin
        il = ia && u_if.issue_is_load;
        dl = hit && u_if.wb_is_load && m_load[r] > 0;
        if (hit && u_if.wb_is_load && m_load[r] == 0) m_err = 1'b1;
        n_load[r] = (m_load[r] + int'(il) - int'(dl)) & MAXC;
      end else begin
        n_load[r] = 0;
      end
    end
    for (int r = 1; r < 32; r++) begin
      m_all[r]  = n_all[r];
      m_load[r] = n_load[r];
    end
  endtask

  // Entered at a falling edge with inputs already driven.
  task automatic cycle(input string tag);
    #1;
    check_outputs(tag);
    model_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit iv, input bit rw, input bit ld, input int d,
                       input int s1, input int s2, input bit wv, input bit wl, input int wd);
    u_if.issue_valid      = iv;
    u_if.issue_reg_write  = rw;
    u_if.issue_is_load    = ld;
    u_if.issue_dest       = 5'(d);
    u_if.decode_read_reg1 = 5'(s1);
    u_if.decode_read_reg2 = 5'(s2);
    u_if.wb_valid         = wv;
    u_if.wb_is_load       = wl;
    u_if.wb_dest          = 5'(wd);
  endtask

  // Asserted between edges so the asynchronous path is what clears state.
  task automatic reset_pulse(input string tag);
    reset = 1'b1;
    #1;
    model_clear();
    check({tag, "_rst_pending"}, u_if.pending_mask, 32'h0);
    check({tag, "_rst_busy"},    u_if.busy, 1'b0);
    check({tag, "_rst_err"},     u_if.err_underflow, 1'b0);
    check_outputs({tag, "_rst"});
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int d, s1, s2, wd;
    bit iv, rw, ld, wv, wl;

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    model_clear();
    #3;
    check_outputs("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Underflow: retire r9 with nothing in flight.
    drive(0, 0, 0, 0, 0, 0, 1, 0, 9);
    cycle("uf");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("uf_err_set", u_if.err_underflow, 1'b1);
    cycle("uf_idle1");
    #1 check("uf_err_hold", u_if.err_underflow, 1'b1);
    cycle("uf_idle2");

    // Reset mid-operation with r5 pending and err set.
    drive(1, 1, 1, 5, 0, 0, 0, 0, 0);
    cycle("pre_rst");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("pre_rst_pending", u_if.pending_mask, 32'h20);
    reset_pulse("mid");

    // Load-use on r5.
    drive(1, 1, 1, 5, 0, 0, 0, 0, 0);
    cycle("lu_issue");
    drive(1, 1, 0, 6, 5, 0, 0, 0, 0);
    #1 check("lu_stall", u_if.stall, 1'b1);
    cycle("lu_hold");
    drive(1, 1, 0, 6, 5, 0, 1, 1, 5);
    #1 check("lu_wb_stall", u_if.stall, 1'b0);
    check("lu_wb_accept", u_if.issue_accept, 1'b1);
    cycle("lu_wb");
    reset_pulse("lu");

    // ALU dependency on r7.
    drive(1, 1, 0, 7, 0, 0, 0, 0, 0);
    cycle("alu_issue");
    drive(1, 1, 0, 8, 7, 0, 0, 0, 0);
    #1 check("alu_stall", u_if.stall, !FWD);
    cycle("alu_dep");
    drive(1, 1, 0, 8, 7, 0, 1, 0, 7);
    #1 check("alu_wb_stall", u_if.stall, 1'b0);
    cycle("alu_wb");
    reset_pulse("alu");

    // Capacity on r3.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 3, 0, 0, 0, 0, 0);
      #1 check("cap_acc", u_if.issue_accept, 1'b1);
      cycle("cap_fill");
    end
    drive(1, 1, 0, 3, 0, 0, 0, 0, 0);
    #1 check("cap_full", u_if.stall, 1'b1);
    cycle("cap_full");
    drive(1, 1, 0, 3, 0, 0, 1, 0, 3);
    #1 check("cap_wb_acc", u_if.issue_accept, 1'b1);
    cycle("cap_wb");
    drive(1, 1, 0, 3, 0, 0, 0, 0, 0);
    #1 check("cap_still_full", u_if.stall, 1'b1);
    cycle("cap_still");
    reset_pulse("cap");

    // Register 0.
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
    #1 check("r0_stall", u_if.stall, 1'b0);
    cycle("r0_issue");
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    #1 check("r0_pending", u_if.pending_mask, 32'h0);
    cycle("r0_wb");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("r0_err", u_if.err_underflow, 1'b0);
    cycle("r0_idle");

    // Randomised traffic over a small register window.
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) reset_pulse("rnd");
      iv = ($urandom_range(0, 3) != 0);
      rw = ($urandom_range(0, 4) != 0);
      ld = $urandom_range(0, 1);
      d  = $urandom_range(0, 7);
      s1 = $urandom_range(0, 7);
      s2 = $urandom_range(0, 7);
      wv = $urandom_range(0, 1);
      wd = $urandom_range(0, 7);
      wl = (m_load[wd] > 0) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
      if (m_all[wd] == 0 && $urandom_range(0, 7) != 0) wv = 1'b0;
      // Keep clear of retiring an empty counter on the register being issued.
      if (wv && iv && rw && wd == d && d != 0 &&
          (m_all[wd] == 0 || (wl && m_load[wd] == 0)))
        wv = 1'b0;
      drive(iv, rw, ld, d, s1, s2, wv, wl, wd);
      cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
